// File: rtl/farm_lane_car_dispatcher.sv
// Farm-road lane car dispatcher.
// Turns a debounced KEY press into one queued car (up to 15 per lane) and
// releases cars one at a time to the animation over valid/ready while the
// farm light is green, with a forced idle gap after every release.
//
// state | meaning
// IDLE  | no car offered; offer next edge if green and cars are waiting
// OFFER | car_valid_o high, held until the animation takes it
// GAP   | spacing between releases; car_valid_o low until the gap expires
module farm_lane_car_dispatcher #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CAR_GAP_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add_car_raw_i,
    input  logic       farm_green_i,
    input  logic       car_ready_i,
    output logic       car_valid_o,
    output logic [3:0] queue_count_o,
    output logic       sensor_o,
    output logic       overflow_o
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GAP_W = (CAR_GAP_CYCLES > 0) ? $clog2(CAR_GAP_CYCLES + 1) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CAR_GAP_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_GAP
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic              r_db_level_d;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_add_pulse;
    logic [3:0]        r_count;
    logic              r_overflow;
    logic              r_valid;
    logic [GAP_W-1:0]  r_gap_cnt;
    state_t            r_state;

    logic              w_handshake;
    logic              w_can_offer;

    assign w_handshake = r_valid & car_ready_i;
    assign w_can_offer = farm_green_i & (r_count != 4'd0);

    // Synchronize the raw key, debounce it, and register a one-cycle rising-edge pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_db_level   <= 1'b0;
            r_db_level_d <= 1'b0;
            r_db_cnt     <= '0;
            r_add_pulse  <= 1'b0;
        end else begin
            r_sync1      <= add_car_raw_i;
            r_sync2      <= r_sync1;
            r_db_level_d <= r_db_level;
            r_add_pulse  <= r_db_level & ~r_db_level_d;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt   <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Saturating queue counter; an add and a release in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (r_add_pulse && !w_handshake) begin
                if (r_count == 4'd15) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 4'd1;
                end
            end else if (w_handshake && !r_add_pulse) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Release FSM; the gap's last cycle makes the idle decision itself so releases stay evenly spaced.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_valid   <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_can_offer) begin
                        r_state <= ST_OFFER;
                        r_valid <= 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (car_ready_i) begin
                        r_valid <= 1'b0;
                        if (CAR_GAP_CYCLES == 0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_gap_cnt <= '0;
                        if (w_can_offer) begin
                            r_state <= ST_OFFER;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign car_valid_o   = r_valid;
    assign queue_count_o = r_count;
    assign sensor_o      = (r_count != 4'd0);
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_farm_lane_car_dispatcher.sv
// Bench for farm_lane_car_dispatcher: directed stimulus, a behavioural lane
// model compared every cycle, and literal expectations at key moments.
module tb_farm_lane_car_dispatcher;

    localparam int DB  = 4;
    localparam int GAP = 3;

    logic       clk;
    logic       reset;
    logic       add_car_raw_i;
    logic       farm_green_i;
    logic       car_ready_i;
    logic       car_valid_o;
    logic [3:0] queue_count_o;
    logic       sensor_o;
    logic       overflow_o;

    int checks   = 0;
    int failures = 0;

    farm_lane_car_dispatcher #(
        .DEBOUNCE_CYCLES(DB),
        .CAR_GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .add_car_raw_i(add_car_raw_i),
        .farm_green_i (farm_green_i),
        .car_ready_i  (car_ready_i),
        .car_valid_o  (car_valid_o),
        .queue_count_o(queue_count_o),
        .sensor_o     (sensor_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: key must be seen stable for DB synced samples, a car is
    // added two edges after acceptance, offers wait GAP edges after a release.
    bit m_s1 = 0, m_s2 = 0, m_db = 0, m_p1 = 0, m_p2 = 0;
    bit m_valid = 0, m_ovf = 0;
    int m_count = 0;
    int m_edge = 0;
    int m_last_hs = -1000;
    bit m_hist[$];

    always @(posedge clk) begin
        bit hs, add, rose, all_new;
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_p1 = 0; m_p2 = 0;
            m_valid = 0; m_ovf = 0; m_count = 0; m_last_hs = -1000;
            m_hist.delete();
        end else begin
            hs  = m_valid && car_ready_i;
            add = m_p2;
            m_p2 = m_p1;
            m_hist.push_back(m_s2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            rose = 0;
            if (m_hist.size() == DB) begin
                all_new = 1;
                foreach (m_hist[k]) if (m_hist[k] == m_db) all_new = 0;
                if (all_new) begin
                    m_db = ~m_db;
                    rose = m_db;
                end
            end
            m_p1 = rose;
            m_s2 = m_s1;
            m_s1 = add_car_raw_i;
            if (m_valid) begin
                if (hs) begin
                    m_valid   = 0;
                    m_last_hs = m_edge;
                end
            end else if (farm_green_i && m_count != 0 && (m_edge - m_last_hs) >= GAP) begin
                m_valid = 1;
            end
            m_ovf = 0;
            if (add && !hs) begin
                if (m_count == 15) m_ovf = 1;
                else m_count = m_count + 1;
            end else if (hs && !add) begin
                m_count = m_count - 1;
            end
        end
        m_edge++;
        #1;
        check("cyc_valid", car_valid_o, m_valid);
        check("cyc_count", queue_count_o, m_count);
        check("cyc_sensor", sensor_o, m_count != 0);
        check("cyc_overflow", overflow_o, m_ovf);
    end

    task automatic press();
        add_car_raw_i = 1'b1;
        tick(10);
        add_car_raw_i = 1'b0;
        tick(10);
    endtask

    initial begin
        int hs_at[$];
        int ovf_cycles;

        reset = 1'b0; add_car_raw_i = 1'b1; farm_green_i = 1'b1; car_ready_i = 1'b0;
        tick(4);
        check("rst_valid", car_valid_o, 0);
        check("rst_count", queue_count_o, 0);
        check("rst_sensor", sensor_o, 0);
        check("rst_overflow", overflow_o, 0);

        // Latency: count appears at edge 7 after release, then an offer follows.
        reset = 1'b1;
        tick(7);
        check("lat_edge6_count", queue_count_o, 0);
        tick(1);
        check("lat_edge7_count", queue_count_o, 1);
        check("lat_model_count", m_count, 1);
        check("lat_sensor", sensor_o, 1);
        add_car_raw_i = 1'b0;
        tick(1);
        check("offer_valid", car_valid_o, 1);
        farm_green_i = 1'b0;
        tick(1);
        check("offer_held_green_low", car_valid_o, 1);
        car_ready_i = 1'b1;
        tick(1);
        check("take_count", queue_count_o, 0);
        check("take_valid", car_valid_o, 0);
        check("take_sensor", sensor_o, 0);
        car_ready_i = 1'b0;
        tick(12);
        check("idle_after_gap", car_valid_o, 0);

        // Short glitch is rejected.
        add_car_raw_i = 1'b1;
        tick(3);
        add_car_raw_i = 1'b0;
        tick(12);
        check("glitch_count", queue_count_o, 0);
        check("glitch_model", m_count, 0);

        // Three cars released with even spacing.
        repeat (3) press();
        check("three_count", queue_count_o, 3);
        farm_green_i = 1'b1; car_ready_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (car_valid_o && car_ready_i) hs_at.push_back(i);
        end
        check("rel_handshakes", hs_at.size(), 3);
        if (hs_at.size() == 3) begin
            check("rel_spacing1", hs_at[1] - hs_at[0], 4);
            check("rel_spacing2", hs_at[2] - hs_at[1], 4);
        end
        check("rel_count", queue_count_o, 0);
        check("rel_sensor", sensor_o, 0);
        farm_green_i = 1'b0; car_ready_i = 1'b0;

        // Fill to 15, then overflow on the 16th press.
        repeat (15) press();
        check("full_count", queue_count_o, 15);
        check("full_sensor", sensor_o, 1);
        ovf_cycles = 0;
        add_car_raw_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (overflow_o) ovf_cycles++;
        end
        add_car_raw_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (overflow_o) ovf_cycles++;
        end
        check("ovf_pulse_cycles", ovf_cycles, 1);
        check("ovf_count", queue_count_o, 15);

        // Add and release in the same cycle at 15.
        farm_green_i = 1'b1;
        tick(2);
        check("full_offer", car_valid_o, 1);
        add_car_raw_i = 1'b1;
        tick(7);
        car_ready_i = 1'b1;
        tick(1);
        check("both_count", queue_count_o, 15);
        check("both_overflow", overflow_o, 0);
        check("both_valid", car_valid_o, 0);
        car_ready_i = 1'b0;
        tick(2);
        check("both_gap_valid", car_valid_o, 0);
        tick(1);
        check("both_reoffer", car_valid_o, 1);
        add_car_raw_i = 1'b0;

        // Reset during a pending offer discards the car.
        reset = 1'b0;
        tick(1);
        check("midrst_valid", car_valid_o, 0);
        check("midrst_count", queue_count_o, 0);
        tick(1);
        reset = 1'b1;
        tick(15);
        check("final_count", queue_count_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
